// File: rtl/mau_pkg.sv
// Shared encodings and helpers for the MEM-stage byte-serial access unit.
package mau_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  function automatic logic [2:0] byte_count(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 3'd1;
      SIZE_HALF: return 3'd2;
      SIZE_WORD: return 3'd4;
      default:   return 3'd0;
    endcase
  endfunction

  // The access address names the least-significant byte, which sits at the
  // top of the group, so halves and words align on the high end.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SIZE_BYTE: return 1'b1;
      SIZE_HALF: return addr_lo[0];
      SIZE_WORD: return &addr_lo;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extender.sv
// Combinational sign/zero extension of a raw little-end-assembled load value.
module load_extender
  import mau_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] result
);

  always_comb begin
    result = raw;
    case (size)
      SIZE_BYTE: result = {{24{~is_unsigned & raw[7]}}, raw[7:0]};
      SIZE_HALF: result = {{16{~is_unsigned & raw[15]}}, raw[15:0]};
      default:   result = raw;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator: serialises one load/store into byte transfers on a
// ready-handshaked byte port, stalling the pipeline until it completes.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              misalign_err,
  output logic              bus_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ready
);

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t            state;
  logic [1:0]        size_q;
  logic              write_q;
  logic              uns_q;
  logic [1:0]        k;
  logic [WAIT_W-1:0] wait_cnt;
  logic [31:0]       wdata_q;
  logic [31:0]       raw_q;
  logic [31:0]       raw_next;
  logic [31:0]       ext_rdata;
  logic              last_byte;
  logic              timeout_hit;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^req_addr[31:ADDR_W];

  assign stall     = ((state == ST_IDLE) && req_valid) || (state == ST_ACCESS);
  assign mem_wdata = wdata_q[7:0];
  assign last_byte = ({1'b0, k} == (byte_count(size_q) - 3'd1));
  assign timeout_hit = (TIMEOUT != 0) && (int'(wait_cnt) == TIMEOUT - 1);

  // Merge the byte arriving this cycle so the final byte can be extended
  // on the same edge that enters DONE.
  always_comb begin
    raw_next = raw_q;
    raw_next[{k, 3'b000} +: 8] = mem_rdata;
  end

  load_extender u_ext (
    .raw         (raw_next),
    .size        (size_q),
    .is_unsigned (uns_q),
    .result      (ext_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      size_q       <= 2'b00;
      write_q      <= 1'b0;
      uns_q        <= 1'b0;
      k            <= 2'd0;
      wait_cnt     <= '0;
      wdata_q      <= 32'h0;
      raw_q        <= 32'h0;
      mem_addr     <= '0;
      mem_re       <= 1'b0;
      mem_we       <= 1'b0;
      resp_valid   <= 1'b0;
      resp_rdata   <= 32'h0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          resp_valid   <= 1'b0;
          resp_rdata   <= 32'h0;
          misalign_err <= 1'b0;
          bus_err      <= 1'b0;
          if (req_valid) begin
            size_q   <= req_size;
            write_q  <= req_write;
            uns_q    <= req_unsigned;
            k        <= 2'd0;
            wait_cnt <= '0;
            raw_q    <= 32'h0;
            if (!is_aligned(req_size, req_addr[1:0])) begin
              state        <= ST_DONE;
              resp_valid   <= 1'b1;
              misalign_err <= 1'b1;
            end else begin
              state    <= ST_ACCESS;
              mem_addr <= req_addr[ADDR_W-1:0];
              mem_re   <= ~req_write;
              mem_we   <= req_write;
              wdata_q  <= req_wdata;
            end
          end
        end

        ST_ACCESS: begin
          if (mem_ready) begin
            raw_q    <= raw_next;
            wait_cnt <= '0;
            if (last_byte) begin
              state      <= ST_DONE;
              mem_re     <= 1'b0;
              mem_we     <= 1'b0;
              wdata_q    <= 32'h0;
              resp_valid <= 1'b1;
              resp_rdata <= write_q ? 32'h0 : ext_rdata;
            end else begin
              k        <= k + 2'd1;
              mem_addr <= mem_addr - ADDR_W'(1);
              wdata_q  <= {8'h00, wdata_q[31:8]};
            end
          end else if (timeout_hit) begin
            // Abandon the access; bytes already stored stay written.
            state      <= ST_DONE;
            mem_re     <= 1'b0;
            mem_we     <= 1'b0;
            wdata_q    <= 32'h0;
            resp_valid <= 1'b1;
            resp_rdata <= 32'h0;
            bus_err    <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        ST_DONE: begin
          state        <= ST_IDLE;
          resp_valid   <= 1'b0;
          resp_rdata   <= 32'h0;
          misalign_err <= 1'b0;
          bus_err      <= 1'b0;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: table of single accesses plus timeout
// and mid-access reset sequences against a byte memory model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        stall;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        misalign_err;
  logic        bus_err;
  logic [9:0]  mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ready = 1'b1;

  logic [7:0]  init_mem [0:1023];
  logic [9:0]  rd_addr [0:255];
  logic [9:0]  wr_addr [0:255];
  logic [7:0]  wr_data [0:255];
  int          rd_n = 0;
  int          wr_n = 0;
  int          stall_total = 0;

  int n_checks = 0;
  int n_fail = 0;

  mem_access_unit #(.ADDR_W(10), .TIMEOUT(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .stall        (stall),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .misalign_err (misalign_err),
    .bus_err      (bus_err),
    .mem_addr     (mem_addr),
    .mem_re       (mem_re),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready)
  );

  always #5 clk = ~clk;

  assign mem_rdata = init_mem[mem_addr];

  always @(posedge clk) begin
    if (mem_re && mem_ready) begin
      rd_addr[rd_n % 256] <= mem_addr;
      rd_n <= rd_n + 1;
    end
    if (mem_we && mem_ready) begin
      wr_addr[wr_n % 256] <= mem_addr;
      wr_data[wr_n % 256] <= mem_wdata;
      wr_n <= wr_n + 1;
    end
  end

  always @(negedge clk) if (stall) stall_total <= stall_total + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_mis;
    int          exp_lat;
    int          exp_n;
  } vec_t;

  vec_t vecs [14];

  task automatic run_vec(input int id, input vec_t v);
    int rs, ws, ss, lat;
    logic got;
    logic [31:0] rdata_s;
    logic mis_s, berr_s;
    logic [31:0] sh;
    rs = rd_n; ws = wr_n; ss = stall_total;
    got = 1'b0; lat = 0; rdata_s = 32'h0; mis_s = 1'b0; berr_s = 1'b0;
    req_write = v.wr; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(posedge clk); #1;
      if (resp_valid) begin
        got = 1'b1; lat = c;
        rdata_s = resp_rdata; mis_s = misalign_err; berr_s = bus_err;
      end
    end
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk($sformatf("v%0d resp_seen", id), {31'h0, got}, 32'h1);
    chk($sformatf("v%0d latency", id), lat, v.exp_lat);
    chk($sformatf("v%0d rdata", id), rdata_s, v.exp_rdata);
    chk($sformatf("v%0d misalign", id), {31'h0, mis_s}, {31'h0, v.exp_mis});
    chk($sformatf("v%0d bus_err", id), {31'h0, berr_s}, 32'h0);
    chk($sformatf("v%0d pulse_1cyc", id), {31'h0, resp_valid}, 32'h0);
    chk($sformatf("v%0d stall_cycles", id), stall_total - ss, v.exp_lat);
    chk($sformatf("v%0d reads", id), rd_n - rs, v.wr ? 0 : v.exp_n);
    chk($sformatf("v%0d writes", id), wr_n - ws, v.wr ? v.exp_n : 0);
    for (int k = 0; k < v.exp_n; k++) begin
      if (v.wr) begin
        sh = v.wdata >> (8 * k);
        chk($sformatf("v%0d wr_addr%0d", id, k), {22'h0, wr_addr[(ws + k) % 256]}, (v.addr - k) & 32'h3FF);
        chk($sformatf("v%0d wr_data%0d", id, k), {24'h0, wr_data[(ws + k) % 256]}, {24'h0, sh[7:0]});
      end else begin
        chk($sformatf("v%0d rd_addr%0d", id, k), {22'h0, rd_addr[(rs + k) % 256]}, (v.addr - k) & 32'h3FF);
      end
    end
  endtask

  initial begin
    int ws, ss, lat;
    logic got, we_wait;
    logic [9:0] addr_wait;
    logic [31:0] rdata_s;
    logic mis_s, berr_s, we_done;

    for (int i = 0; i < 1024; i++) init_mem[i] = 8'h00;
    init_mem[10'h004] = 8'h00; init_mem[10'h005] = 8'h00;
    init_mem[10'h006] = 8'h00; init_mem[10'h007] = 8'h08;
    init_mem[10'h010] = 8'h80; init_mem[10'h011] = 8'h7F;
    init_mem[10'h030] = 8'h92; init_mem[10'h031] = 8'h34;
    init_mem[10'h008] = 8'h7F; init_mem[10'h009] = 8'h01;
    init_mem[10'h00A] = 8'h02; init_mem[10'h00B] = 8'h03;

    //            wr    size   uns   addr           wdata          exp_rdata     mis  lat n
    vecs[0]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0007, 32'h0,         32'h0000_0008, 1'b0, 5, 4};
    vecs[1]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0010, 32'h0,         32'hFFFF_FF80, 1'b0, 2, 1};
    vecs[2]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0010, 32'h0,         32'h0000_0080, 1'b0, 2, 1};
    vecs[3]  = '{1'b1, 2'b01, 1'b0, 32'h0000_0021, 32'h1234_ABCD, 32'h0,         1'b0, 3, 2};
    vecs[4]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0,         32'h0,         1'b1, 1, 0};
    vecs[5]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0031, 32'h0,         32'hFFFF_9234, 1'b0, 3, 2};
    vecs[6]  = '{1'b0, 2'b01, 1'b1, 32'h0000_0031, 32'h0,         32'h0000_9234, 1'b0, 3, 2};
    vecs[7]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0030, 32'h0,         32'h0,         1'b1, 1, 0};
    vecs[8]  = '{1'b0, 2'b11, 1'b0, 32'h0000_0033, 32'h0,         32'h0,         1'b1, 1, 0};
    vecs[9]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0043, 32'hDEAD_BEEF, 32'h0,         1'b0, 5, 4};
    vecs[10] = '{1'b0, 2'b10, 1'b0, 32'hFFFF_F00B, 32'h0,         32'h7F01_0203, 1'b0, 5, 4};
    vecs[11] = '{1'b0, 2'b00, 1'b0, 32'h0000_0011, 32'h0,         32'h0000_007F, 1'b0, 2, 1};
    vecs[12] = '{1'b1, 2'b00, 1'b0, 32'h0000_0050, 32'h0000_00A5, 32'h0,         1'b0, 2, 1};
    vecs[13] = '{1'b1, 2'b01, 1'b0, 32'h0000_0032, 32'h5555_5555, 32'h0,         1'b1, 1, 0};

    // Reset state
    #12;
    chk("rst stall", {31'h0, stall}, 32'h0);
    chk("rst resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst strobes", {30'h0, mem_re, mem_we}, 32'h0);
    chk("rst mem_addr", {22'h0, mem_addr}, 32'h0);
    chk("rst flags", {30'h0, misalign_err, bus_err}, 32'h0);
    chk("rst rdata", resp_rdata, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

    // Store stalls on byte 1 until the wait counter expires
    ws = wr_n; ss = stall_total; got = 1'b0; lat = 0;
    we_wait = 1'b0; addr_wait = '0; rdata_s = 32'h0; mis_s = 1'b0; berr_s = 1'b0; we_done = 1'b1;
    req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h63; req_wdata = 32'h1122_3344; req_valid = 1'b1; mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    for (int c = 3; c <= 40 && !got; c++) begin
      @(posedge clk); #1;
      if (c == 17) begin we_wait = mem_we; addr_wait = mem_addr; end
      if (resp_valid) begin
        got = 1'b1; lat = c; rdata_s = resp_rdata;
        mis_s = misalign_err; berr_s = bus_err; we_done = mem_we;
      end
    end
    req_valid = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    chk("to resp_seen", {31'h0, got}, 32'h1);
    chk("to latency", lat, 18);
    chk("to bus_err", {31'h0, berr_s}, 32'h1);
    chk("to misalign", {31'h0, mis_s}, 32'h0);
    chk("to rdata", rdata_s, 32'h0);
    chk("to we_waiting", {31'h0, we_wait}, 32'h1);
    chk("to addr_waiting", {22'h0, addr_wait}, 32'h062);
    chk("to we_dropped", {31'h0, we_done}, 32'h0);
    chk("to writes", wr_n - ws, 1);
    chk("to wr_data0", {24'h0, wr_data[ws % 256]}, 32'h44);
    chk("to stall_cycles", stall_total - ss, 18);

    // Reset in the middle of a word load (k=2)
    req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h7; req_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid re", {31'h0, mem_re}, 32'h1);
    chk("mid addr", {22'h0, mem_addr}, 32'h005);
    rst_n = 1'b0; req_valid = 1'b0;
    #1;
    chk("arst re", {31'h0, mem_re}, 32'h0);
    chk("arst stall", {31'h0, stall}, 32'h0);
    chk("arst resp_valid", {31'h0, resp_valid}, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_vec(100, vecs[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "bench time limit reached");
  end

endmodule
